// File: rtl/float_to_twos_pkg.sv
// float_to_twos_pkg: shared widths, field positions and state encodings for the float code paths
package float_to_twos_pkg;
  localparam int FLOAT_W = 8;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int TC_W = 12;
  localparam int S_BIT = 7;
  localparam int E_HI = 6;
  localparam int E_LO = 4;
  localparam int F_HI = 3;
  localparam int F_LO = 0;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/float_to_twos.sv
// float_to_twos: iterative decoder of an 8-bit {S,E,F} float code into a TC_W-bit two's complement value
module float_to_twos
  import float_to_twos_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] float_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TC_W-1:0]    two_comp
);
  state_t state, state_n;
  logic [TC_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic sgn;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == '0 ? DONE : SHIFT) :
              state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mag <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      two_comp <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        sgn <= float_in[S_BIT];
        cnt <= float_in[E_HI:E_LO];
        mag <= TC_W'(float_in[F_HI:F_LO]);
      end
      if (state == SHIFT && cnt != '0) begin
        mag <= mag << 1;
        cnt <= cnt - 1'b1;
      end
      // negating a zero magnitude yields zero, so negative zero never appears
      if (state == SHIFT && cnt == '0)
        two_comp <= sgn ? -mag : mag;
    end
  end
endmodule

// File: tb/tb_float_to_twos.sv
// tb_float_to_twos: scoreboard bench comparing decoded values and latency against an arithmetic model
module tb_float_to_twos;
  typedef struct {
    logic [11:0] v;
    int lat;
    int acc;
  } exp_t;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, man_rdy, rnd_rdy, auto_rdy;
  logic [7:0] float_in;
  logic [11:0] two_comp;
  int cyc, n_checks, n_fail;
  exp_t sb[$];
  exp_t cur;
  logic seen, hs;
  float_to_twos dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .float_in(float_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .two_comp(two_comp)
  );
  assign out_ready = auto_rdy ? rnd_rdy : man_rdy;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    rnd_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask
  task automatic send(input logic [7:0] code, input bit use_lit, input logic [11:0] lit);
    int n = 0;
    int v;
    exp_t e;
    float_in = code;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    v = int'(code[3:0]) * (1 << code[6:4]);
    if (code[7]) v = -v;
    e.v = use_lit ? lit : v[11:0];
    e.lat = int'(code[6:4]) + 1;
    e.acc = cyc;
    sb.push_back(e);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || !in_ready) fail_now("drain");
  endtask
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
      hs = 1'b0;
    end else begin
      if (hs) begin
        chk("ready_after_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        hs = 1'b0;
      end
      if (out_valid) begin
        chk("no_overlap", {31'd0, in_ready}, 32'd0);
        if (!seen) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h, expected none", two_comp);
          end else begin
            cur = sb.pop_front();
            chk("value", {20'd0, two_comp}, {20'd0, cur.v});
            chk("latency", cyc - cur.acc, cur.lat);
          end
          seen = 1'b1;
        end else
          chk("hold", {20'd0, two_comp}, {20'd0, cur.v});
        if (out_ready) begin
          hs = 1'b1;
          seen = 1'b0;
        end
      end
    end
  end
  initial begin
    int n;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    seen = 1'b0;
    hs = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    float_in = 8'h00;
    man_rdy = 1'b1;
    auto_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_two_comp", {20'd0, two_comp}, 32'd0);
    send(8'b0_011_1010, 1'b1, 12'd80);
    wait_idle();
    send(8'b1_111_1111, 1'b1, 12'b1000_1000_0000);
    wait_idle();
    send(8'b1_000_0000, 1'b1, 12'd0);
    wait_idle();
    man_rdy = 1'b0;
    send(8'b0_101_1001, 1'b1, 12'd288);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail_now("bp_out_valid_rise");
    float_in = 8'b0_001_0011;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_two_comp", {20'd0, two_comp}, 32'd288);
    end
    man_rdy = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    man_rdy = 1'b0;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_single_transfer", sb.size(), 32'd0);
    man_rdy = 1'b1;
    send(8'b0_110_1111, 1'b1, 12'd960);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_two_comp", {20'd0, two_comp}, 32'd0);
    send(8'b0_001_0011, 1'b1, 12'd6);
    wait_idle();
    auto_rdy = 1'b1;
    for (int c = 0; c < 256; c++) begin
      send(c[7:0], 1'b0, 12'd0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom), 1'b0, 12'd0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
